taint_event_arbiter: RTL and testbench

Collects the `taint_sum` outputs of N instrumented taint cells (flip-flop and memory shadows) and detects every change in their values. Each change becomes an event record. A round-robin arbiter moves the records into one shared event FIFO, which the simulation taint logger drains over a valid/ready port. The block sits between the instrumented design and the taint log sink, and also reports a running global taint total.

---
 rtl/taint_evt_pkg.sv | 27 ++
 rtl/taint_evt_fifo.sv | 52 +++++
 rtl/taint_event_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_taint_event_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taint_evt_pkg.sv
// Shared types for the taint event arbiter: FSM states, event record, counter limit.
// The record carries a timestamp field only when TAINT_EVT_TS_EN is defined.
package taint_evt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNAP  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } evt_state_e;

  localparam logic [15:0] COAL_MAX = 16'hFFFF;

  localparam int EVT_IDX_W = 3;
  localparam int EVT_SUM_W = 8;
  localparam int EVT_TS_W  = 32;

  // Record layout at the default configuration, matching the FIFO entry packing.
  typedef struct packed {
    logic [EVT_IDX_W-1:0] src;
    logic [EVT_SUM_W-1:0] sum;
`ifdef TAINT_EVT_TS_EN
    logic [EVT_TS_W-1:0]  ts;
`endif
  } evt_rec_t;

endpackage

// File: rtl/taint_evt_fifo.sv
// First-word-fall-through synchronous FIFO; push is accepted when full if a pop
// happens in the same cycle. DEPTH must be a power of two.
module taint_evt_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             pos_clk,
  input  logic             pos_arst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_pop;
  logic             do_push;

  assign do_pop     = pop && (count_reg != '0);
  assign do_push    = push && ((count_reg != CW'(DEPTH)) || do_pop);
  assign head_valid = (count_reg != '0);
  assign head_data  = mem_reg[rd_ptr_reg];
  assign count      = count_reg;

  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int k = 0; k < DEPTH; k++) mem_reg[k] <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/taint_event_arbiter.sv
// Detects changes on N taint_sum inputs, arbitrates pending events round-robin into
// a shared FIFO. Optional timestamps are enabled by defining TAINT_EVT_TS_EN.
module taint_event_arbiter
  import taint_evt_pkg::*;
#(
  parameter int  N_SRC      = 8,
  parameter int  SUM_W      = 8,
  parameter int  FIFO_DEPTH = 4,
`ifdef TAINT_EVT_TS_EN
  parameter int  TS_W       = 32,
`endif
  localparam int IDX_W      = $clog2(N_SRC)
) (
  input  logic                   pos_clk,
  input  logic                   pos_arst,
  input  logic                   en,
  input  logic [N_SRC*SUM_W-1:0] src_sum,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [IDX_W-1:0]       evt_src,
  output logic [SUM_W-1:0]       evt_sum,
`ifdef TAINT_EVT_TS_EN
  output logic [TS_W-1:0]        evt_ts,
`endif
  output logic [SUM_W+IDX_W-1:0] total_sum,
  output logic [15:0]            coalesce_cnt,
  output logic                   busy
);

  localparam int TOT_W = SUM_W + IDX_W;
`ifdef TAINT_EVT_TS_EN
  localparam int REC_W = IDX_W + SUM_W + TS_W;
`else
  localparam int REC_W = IDX_W + SUM_W;
`endif
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  evt_state_e       state_reg, state_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [N_SRC-1:0] pending_w, chg_w, gnt_vec, coal_vec;
  logic [SUM_W-1:0] pval_w [N_SRC];
  logic             arb_on, sample_on, pop, push_ok, grant, gnt_any;
  logic [IDX_W-1:0] gnt_idx;
  logic [CNT_W-1:0] fifo_count;
  logic [REC_W-1:0] push_rec, head_rec;
  logic [16:0]      coal_sum;
  logic [15:0]      coal_next;
  logic [TOT_W-1:0] total_next;
`ifdef TAINT_EVT_TS_EN
  logic [TS_W-1:0]  ts_reg;
  logic [TS_W-1:0]  pts_w [N_SRC];
`endif

  assign arb_on    = (state_reg == RUN) || (state_reg == DRAIN);
  assign sample_on = (state_reg == RUN);
  assign busy      = (state_reg != IDLE);
  assign pop       = evt_valid & evt_ready;
  assign push_ok   = (int'(fifo_count) < FIFO_DEPTH) || pop;
  assign grant     = arb_on && gnt_any && push_ok;

  // Scan from the far end so the pending source closest to rr_ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (pending_w[(int'(rr_ptr_reg) + k) % N_SRC]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'((int'(rr_ptr_reg) + k) % N_SRC);
      end
    end
  end

  assign rr_ptr_next = (gnt_idx == IDX_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    logic [SUM_W-1:0] cur;
    logic [SUM_W-1:0] shadow_reg;
    logic [SUM_W-1:0] pval_reg;
    logic             pending_reg;
`ifdef TAINT_EVT_TS_EN
    logic [TS_W-1:0]  pts_reg;
    assign pts_w[gi] = pts_reg;
`endif

    assign cur          = src_sum[gi*SUM_W +: SUM_W];
    assign chg_w[gi]    = sample_on && (cur != shadow_reg);
    assign gnt_vec[gi]  = grant && (gnt_idx == IDX_W'(gi));
    assign coal_vec[gi] = chg_w[gi] && pending_reg && !gnt_vec[gi];
    assign pending_w[gi] = pending_reg;
    assign pval_w[gi]    = pval_reg;

    // A detection on the granted source re-arms pending with the new value.
    always_ff @(posedge pos_clk or posedge pos_arst) begin
      if (pos_arst) begin
        shadow_reg  <= '0;
        pval_reg    <= '0;
        pending_reg <= 1'b0;
`ifdef TAINT_EVT_TS_EN
        pts_reg     <= '0;
`endif
      end else begin
        if ((state_reg == SNAP) || chg_w[gi]) shadow_reg <= cur;
        if (chg_w[gi]) begin
          pending_reg <= 1'b1;
          pval_reg    <= cur;
`ifdef TAINT_EVT_TS_EN
          pts_reg     <= ts_reg;
`endif
        end else if (gnt_vec[gi]) begin
          pending_reg <= 1'b0;
        end
      end
    end
  end

`ifdef TAINT_EVT_TS_EN
  assign push_rec = {gnt_idx, pval_w[gnt_idx], pts_w[gnt_idx]};
  assign {evt_src, evt_sum, evt_ts} = head_rec;

  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) ts_reg <= '0;
    else          ts_reg <= ts_reg + 1'b1;
  end
`else
  assign push_rec = {gnt_idx, pval_w[gnt_idx]};
  assign {evt_src, evt_sum} = head_rec;
`endif

  taint_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .pos_clk    (pos_clk),
    .pos_arst   (pos_arst),
    .push       (grant),
    .push_data  (push_rec),
    .pop        (pop),
    .head_valid (evt_valid),
    .head_data  (head_rec),
    .count      (fifo_count)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en) state_next = SNAP;
      SNAP:    state_next = RUN;
      RUN:     if (!en) state_next = DRAIN;
      DRAIN:   if (pending_w == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Several sources may coalesce in the same cycle; each one counts.
  always_comb begin
    coal_sum = {1'b0, coalesce_cnt};
    for (int k = 0; k < N_SRC; k++) coal_sum = coal_sum + 17'(coal_vec[k]);
    coal_next = (coal_sum > 17'(COAL_MAX)) ? COAL_MAX : coal_sum[15:0];
  end

  always_comb begin
    total_next = '0;
    for (int k = 0; k < N_SRC; k++)
      total_next = total_next + TOT_W'(src_sum[k*SUM_W +: SUM_W]);
  end

  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      total_sum    <= '0;
      coalesce_cnt <= '0;
    end else begin
      state_reg    <= state_next;
      if (grant) rr_ptr_reg <= rr_ptr_next;
      total_sum    <= total_next;
      coalesce_cnt <= coal_next;
    end
  end

endmodule

// File: tb/tb_taint_event_arbiter.sv
// Bench for taint_event_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model. Timestamp checks are built when TAINT_EVT_TS_EN is defined.
`timescale 1ns/1ps
module tb_taint_event_arbiter;

  localparam int N  = 8;
  localparam int SW = 8;
  localparam int D  = 4;
  localparam int IW = 3;
  localparam int TW = 32;

  logic            pos_clk = 1'b0;
  logic            pos_arst;
  logic            en;
  logic [N*SW-1:0] src_sum;
  logic            evt_valid;
  logic            evt_ready;
  logic [IW-1:0]   evt_src;
  logic [SW-1:0]   evt_sum;
  logic [SW+IW-1:0] total_sum;
  logic [15:0]     coalesce_cnt;
  logic            busy;
`ifdef TAINT_EVT_TS_EN
  logic [TW-1:0]   evt_ts;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int unsigned cyc = 0;

  always #5 pos_clk = ~pos_clk;

  taint_event_arbiter dut (
    .pos_clk      (pos_clk),
    .pos_arst     (pos_arst),
    .en           (en),
    .src_sum      (src_sum),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_src      (evt_src),
    .evt_sum      (evt_sum),
`ifdef TAINT_EVT_TS_EN
    .evt_ts       (evt_ts),
`endif
    .total_sum    (total_sum),
    .coalesce_cnt (coalesce_cnt),
    .busy         (busy)
  );

  // Reference model: ms 0=idle 1=baseline 2=monitoring 3=draining
  typedef struct {
    int          src;
    int          sum;
    int unsigned ts;
  } rec_t;

  rec_t        mq[$];
  int          ms;
  int          mshadow[N];
  int          mpval[N];
  bit          mpend[N];
  int unsigned mpts[N];
  int          mrr;
  int          mcoal;
  int          mtot;
  int unsigned mts;

  task automatic model_reset();
    mq.delete();
    ms = 0; mrr = 0; mcoal = 0; mtot = 0; mts = 0;
    for (int i = 0; i < N; i++) begin
      mshadow[i] = 0; mpval[i] = 0; mpend[i] = 0; mpts[i] = 0;
    end
  endtask

  task automatic model_step();
    bit   pop, g, anyp;
    int   gidx, v;
    rec_t r;
    pop  = (mq.size() > 0) && (evt_ready === 1'b1);
    g    = 0; gidx = 0; anyp = 0;
    for (int i = 0; i < N; i++) anyp |= mpend[i];
    if (ms == 2 || ms == 3)
      for (int k = 0; k < N; k++)
        if (!g && mpend[(mrr + k) % N]) begin g = 1; gidx = (mrr + k) % N; end
    if (g && !(mq.size() < D || pop)) g = 0;
    if (pop) void'(mq.pop_front());
    if (g) begin
      r.src = gidx; r.sum = mpval[gidx]; r.ts = mpts[gidx];
      mq.push_back(r);
      mpend[gidx] = 0;
      mrr = (gidx + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      v = int'(src_sum[i*SW +: SW]);
      if (ms == 1) mshadow[i] = v;
      else if (ms == 2 && v != mshadow[i]) begin
        if (mpend[i] && mcoal < 65535) mcoal++;
        mshadow[i] = v; mpend[i] = 1; mpval[i] = v; mpts[i] = mts;
      end
    end
    case (ms)
      0: if (en) ms = 1;
      1: ms = 2;
      2: if (!en) ms = 3;
      3: if (!anyp) ms = 0;
      default: ms = 0;
    endcase
    mtot = 0;
    for (int i = 0; i < N; i++) mtot += int'(src_sum[i*SW +: SW]);
    mts++;
  endtask

  task automatic tick();
    model_step();
    @(posedge pos_clk);
    #1;
    cyc++;
  endtask

  task automatic set_src(input int i, input int v);
    src_sum[i*SW +: SW] = SW'(v);
  endtask

  task automatic test_reset();
    pos_arst = 1'b1; en = 1'b0; evt_ready = 1'b0; src_sum = '0;
    model_reset();
    repeat (3) @(posedge pos_clk);
    #3 pos_arst = 1'b0;
    cyc = 0;
    tick();
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (total_sum !== '0) begin n_errors++; $display("FAIL reset_total: got %0h want 0", total_sum); end
    n_checks++; if (coalesce_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_coal: got %0d want 0", coalesce_cnt); end
    $display("reset: valid=%b busy=%b total=%0h", evt_valid, busy, total_sum);
  endtask

  task automatic test_snap_detect();
    int unsigned det_ts;
    set_src(0, 3); en = 1'b1;
    repeat (3) tick();
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL snap_no_event: got valid %b want 0", evt_valid); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL snap_busy: got %b want 1", busy); end
    n_checks++; if (total_sum !== 11'd3) begin n_errors++; $display("FAIL snap_total: got %0d want 3", total_sum); end
    set_src(2, 5);
    det_ts = cyc;
    tick();
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL detect_early: got valid %b want 0", evt_valid); end
    tick();
    n_checks++; if (evt_valid !== 1'b1 || evt_src !== 3'd2 || evt_sum !== 8'd5) begin
      n_errors++; $display("FAIL detect_record: got v=%b src=%0d sum=%0d want v=1 src=2 sum=5", evt_valid, evt_src, evt_sum); end
`ifdef TAINT_EVT_TS_EN
    n_checks++; if (evt_ts !== det_ts) begin n_errors++; $display("FAIL detect_ts: got %0d want %0d", evt_ts, det_ts); end
`endif
    $display("detect: src=%0d sum=%0d det_ts=%0d", evt_src, evt_sum, det_ts);
    evt_ready = 1'b1;
    tick();
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL detect_pop: got valid %b want 0", evt_valid); end
  endtask

  task automatic test_round_robin();
    int exp_src[3] = '{6, 1, 4};
    int exp_sum[3] = '{8'h66, 8'h11, 8'h44};
    set_src(4, 9);
    repeat (3) tick();
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL rr_setup: got valid %b want 0", evt_valid); end
    set_src(1, 8'h11); set_src(4, 8'h44); set_src(6, 8'h66);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (evt_valid !== 1'b1 || int'(evt_src) !== exp_src[k] || int'(evt_sum) !== exp_sum[k]) begin
        n_errors++; $display("FAIL rr_order[%0d]: got v=%b src=%0d sum=%0h want src=%0d sum=%0h", k, evt_valid, evt_src, evt_sum, exp_src[k], exp_sum[k]); end
      $display("rr: k=%0d src=%0d sum=%0h", k, evt_src, evt_sum);
    end
    tick();
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL rr_empty: got valid %b want 0", evt_valid); end
  endtask

  task automatic test_coalesce();
    int exp_src[5] = '{5, 7, 0, 1, 3};
    int exp_sum[5] = '{8'h25, 8'h27, 8'h20, 8'h21, 8'h33};
    evt_ready = 1'b0;
    set_src(0, 8'h20); set_src(1, 8'h21); set_src(3, 8'h23); set_src(5, 8'h25); set_src(7, 8'h27);
    repeat (6) tick();
    n_checks++; if (evt_valid !== 1'b1 || evt_src !== 3'd5) begin
      n_errors++; $display("FAIL coal_full_head: got v=%b src=%0d want v=1 src=5", evt_valid, evt_src); end
    n_checks++; if (coalesce_cnt !== 16'd0) begin n_errors++; $display("FAIL coal_pre: got %0d want 0", coalesce_cnt); end
    set_src(3, 8'h33);
    tick();
    n_checks++; if (coalesce_cnt !== 16'd1) begin n_errors++; $display("FAIL coal_count: got %0d want 1", coalesce_cnt); end
    evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (evt_valid !== 1'b1 || int'(evt_src) !== exp_src[k] || int'(evt_sum) !== exp_sum[k]) begin
        n_errors++; $display("FAIL coal_drain[%0d]: got v=%b src=%0d sum=%0h want src=%0d sum=%0h", k, evt_valid, evt_src, evt_sum, exp_src[k], exp_sum[k]); end
      $display("coalesce: k=%0d src=%0d sum=%0h", k, evt_src, evt_sum);
      tick();
    end
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL coal_empty: got valid %b want 0", evt_valid); end
  endtask

  task automatic test_drain();
    int exp_src[3] = '{4, 6, 2};
    int exp_sum[3] = '{8'h54, 8'h56, 8'h52};
    evt_ready = 1'b0;
    set_src(2, 8'h52); set_src(4, 8'h54); set_src(6, 8'h56);
    tick();
    en = 1'b0;
    tick();
    set_src(0, 8'h99);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL drain_busy[%0d]: got %b want 1", k, busy); end
      tick();
    end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL drain_busy_last: got %b want 1", busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL drain_idle: got %b want 0", busy); end
    evt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (evt_valid !== 1'b1 || int'(evt_src) !== exp_src[k] || int'(evt_sum) !== exp_sum[k]) begin
        n_errors++; $display("FAIL drain_rec[%0d]: got v=%b src=%0d sum=%0h want src=%0d sum=%0h", k, evt_valid, evt_src, evt_sum, exp_src[k], exp_sum[k]); end
      $display("drain: k=%0d src=%0d sum=%0h", k, evt_src, evt_sum);
      tick();
    end
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL drain_no_event: got valid %b want 0", evt_valid); end
  endtask

  task automatic test_async_reset();
    en = 1'b1; evt_ready = 1'b0;
    repeat (2) tick();
    set_src(1, 8'h61); set_src(3, 8'h63); set_src(5, 8'h65);
    repeat (3) tick();
    n_checks++; if (evt_valid !== 1'b1) begin n_errors++; $display("FAIL arst_pre: got valid %b want 1", evt_valid); end
    #2 pos_arst = 1'b1;
    #1;
    n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL arst_valid: got %b want 0", evt_valid); end
    n_checks++; if (busy !== 1'b0 || coalesce_cnt !== 16'd0) begin
      n_errors++; $display("FAIL arst_state: got busy=%b coal=%0d want 0 0", busy, coalesce_cnt); end
    model_reset();
    #2 pos_arst = 1'b0;
    cyc = 0;
    evt_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++; if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL arst_stale[%0d]: got valid %b want 0", k, evt_valid); end
    end
    $display("async_reset: valid=%b busy=%b", evt_valid, busy);
  endtask

  task automatic test_total();
    for (int i = 0; i < N; i++) set_src(i, 8'hFF);
    tick();
    n_checks++; if (total_sum !== 11'h7F8) begin n_errors++; $display("FAIL total_max: got %0h want 7f8", total_sum); end
    $display("total: %0h", total_sum);
  endtask

  task automatic test_random();
    int nchg;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 24) == 0) en = ~en;
      evt_ready = ($urandom_range(0, 99) < 55);
      nchg = $urandom_range(0, 3);
      for (int j = 0; j < nchg; j++) set_src($urandom_range(0, N-1), $urandom_range(0, 255));
      tick();
      n_checks++;
      if (evt_valid !== (mq.size() > 0) || busy !== (ms != 0) || int'(total_sum) !== mtot || int'(coalesce_cnt) !== mcoal) begin
        n_errors++;
        $display("FAIL rand_status[%0d]: got v=%b busy=%b tot=%0d coal=%0d want v=%0d busy=%0d tot=%0d coal=%0d",
                 c, evt_valid, busy, total_sum, coalesce_cnt, mq.size() > 0, ms != 0, mtot, mcoal);
      end else if (mq.size() > 0) begin
        n_checks++;
        if (int'(evt_src) !== mq[0].src || int'(evt_sum) !== mq[0].sum) begin
          n_errors++;
          $display("FAIL rand_head[%0d]: got src=%0d sum=%0d want src=%0d sum=%0d", c, evt_src, evt_sum, mq[0].src, mq[0].sum);
        end
`ifdef TAINT_EVT_TS_EN
        n_checks++;
        if (evt_ts !== mq[0].ts) begin
          n_errors++; $display("FAIL rand_ts[%0d]: got %0d want %0d", c, evt_ts, mq[0].ts);
        end
`endif
      end
      $display("rand: c=%0d en=%b rdy=%b v=%b src=%0d sum=%0h coal=%0d", c, en, evt_ready, evt_valid, evt_src, evt_sum, coalesce_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_snap_detect();
    test_round_robin();
    test_coalesce();
    test_drain();
    test_async_reset();
    test_total();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
